// File: rtl/draw_rect_pkg.sv
// Shared definitions for the falling-rectangle controller: state encoding
// and default screen geometry.
package draw_rect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_RISE = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    localparam int RECT_HEIGHT     = 235;
    localparam int SCREEN_HEIGHT   = 600;
    localparam int DEF_FLOOR_Y     = SCREEN_HEIGHT - RECT_HEIGHT;
    localparam int DEF_X_MAX       = 565;
    localparam int DEF_TICK_CYCLES = 1000000;

endpackage

// File: rtl/draw_rect_fall_ctl_tick_gen.sv
// Motion-step timer: counts 0..TICK_CYCLES-1 while enabled and flags the
// last count, so the physics advances once per full period.
module tick_gen #(
    parameter int TICK_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/draw_rect_fall_ctl.sv
// Drops a rectangle from the pointer position on a left click and lets it
// bounce with damping until it rests on the floor; a second click re-arms it.
module draw_rect_fall_ctl
    import draw_rect_pkg::*;
#(
    parameter int W           = 12,
    parameter int FLOOR_Y     = DEF_FLOOR_Y,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int GRAVITY     = 1,
    parameter int DAMP_SHIFT  = 1,
    parameter int V_MIN       = 2
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         mouse_left,
    input  logic [W-1:0] mouse_xpos,
    input  logic [W-1:0] mouse_ypos,
    output logic [W-1:0] xpos,
    output logic [W-1:0] ypos,
    output logic [1:0]   state_o,
    output logic         landed,
    output logic [3:0]   bounces
);

    localparam logic [W-1:0] FLOOR_W = W'(FLOOR_Y);
    localparam logic [W:0]   FLOOR_X = (W+1)'(FLOOR_Y);
    localparam logic [W-1:0] XMAX_W  = W'(X_MAX);
    localparam logic [W-1:0] GRAV_W  = W'(GRAVITY);
    localparam logic [W-1:0] VMIN_W  = W'(V_MIN);

    state_t       r_state;
    logic [W-1:0] r_xpos;
    logic [W-1:0] r_ypos;
    logic [W-1:0] r_vel;
    logic         r_prev;
    logic         r_landed;
    logic [3:0]   r_bounces;

    state_t       w_state_next;
    logic [W-1:0] w_xpos_next;
    logic [W-1:0] w_ypos_next;
    logic [W-1:0] w_vel_next;
    logic         w_landed_next;
    logic [3:0]   w_bounces_next;
    logic         w_press;
    logic         w_clr;
    logic         w_tick;
    logic [W:0]   w_vel_inc;
    logic [W-1:0] w_vel_up;
    logic [W:0]   w_sum;
    logic [W-1:0] w_vel_damp;
    logic [W-1:0] w_vel_down;
    logic [3:0]   w_bounce_inc;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (r_state != ST_IDLE),
        .tick  (w_tick)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_xpos    <= '0;
            r_ypos    <= '0;
            r_vel     <= '0;
            r_prev    <= 1'b0;
            r_landed  <= 1'b0;
            r_bounces <= '0;
        end else begin
            r_state   <= w_state_next;
            r_xpos    <= w_xpos_next;
            r_ypos    <= w_ypos_next;
            r_vel     <= w_vel_next;
            r_prev    <= mouse_left;
            r_landed  <= w_landed_next;
            r_bounces <= w_bounces_next;
        end
    end

    // The floor test uses one extra bit so a large velocity cannot wrap
    // ypos past the floor and back into range.
    always_comb begin
        w_press        = mouse_left & ~r_prev;
        w_vel_inc      = {1'b0, r_vel} + {1'b0, GRAV_W};
        w_vel_up       = w_vel_inc[W] ? '1 : w_vel_inc[W-1:0];
        w_sum          = {1'b0, r_ypos} + {1'b0, w_vel_up};
        w_vel_damp     = w_vel_up >> DAMP_SHIFT;
        w_vel_down     = r_vel - GRAV_W;
        w_bounce_inc   = (r_bounces == 4'hF) ? 4'hF : r_bounces + 4'd1;
        w_xpos_next    = (mouse_xpos > XMAX_W) ? XMAX_W : mouse_xpos;
        w_state_next   = r_state;
        w_ypos_next    = r_ypos;
        w_vel_next     = r_vel;
        w_bounces_next = r_bounces;
        w_clr          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ypos_next    = mouse_ypos;
                w_vel_next     = '0;
                w_bounces_next = '0;
                if (w_press) begin
                    w_state_next = ST_FALL;
                    w_clr        = 1'b1;
                end
            end
            ST_FALL: begin
                if (w_tick) begin
                    if (w_sum >= FLOOR_X) begin
                        w_ypos_next    = FLOOR_W;
                        w_vel_next     = w_vel_damp;
                        w_bounces_next = w_bounce_inc;
                        w_state_next   = (w_vel_damp >= VMIN_W) ? ST_RISE : ST_DOWN;
                    end else begin
                        w_ypos_next = w_sum[W-1:0];
                        w_vel_next  = w_vel_up;
                    end
                end
            end
            ST_RISE: begin
                if (w_tick) begin
                    if (r_vel <= GRAV_W) begin
                        w_vel_next   = '0;
                        w_state_next = ST_FALL;
                    end else begin
                        w_vel_next  = w_vel_down;
                        w_ypos_next = (w_vel_down > r_ypos) ? '0 : r_ypos - w_vel_down;
                    end
                end
            end
            ST_DOWN: begin
                w_ypos_next = FLOOR_W;
                w_vel_next  = '0;
                if (w_press) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_landed_next = (w_state_next == ST_DOWN) && (r_state != ST_DOWN);
    end

    assign xpos    = r_xpos;
    assign ypos    = r_ypos;
    assign state_o = r_state;
    assign landed  = r_landed;
    assign bounces = r_bounces;

endmodule
